// File: rtl/clock_bcd_seq.sv
// clock_bcd_seq: converts NUM_FIELDS packed binary time fields to BCD with one shared
// sequential double-dabble engine that serves the fields one after another.
// An input snapshot is taken on start. The snapshot gets the 12h remap on the hour
// field, per-field overflow saturation and optional leading-zero blanking.
//
// Ports:
//   i_clk       clock
//   i_reset_n   synchronous active-low reset
//   i_start     conversion request, sampled when idle or on the edge leaving done
//   i_fields    field f at [f*BIN_WIDTH +: BIN_WIDTH]
//   i_mode_12h  12-hour remap of field HOUR_IDX, sampled with i_start
//   i_blank_lz  leading-zero blanking enable, sampled with i_start
//   o_busy      high whenever the engine is not idle
//   o_valid     one-cycle pulse when new results appear on o_bcd/o_overflow/o_pm
//   o_bcd       field f digit d (d=0 is the LSD) at [(f*BCD_DIGITS+d)*4 +: 4]
//   o_overflow  per-field saturation flag
//   o_pm        PM indicator, only ever set in 12h mode
module clock_bcd_seq #(
    parameter int unsigned NUM_FIELDS = 3,
    parameter int unsigned BIN_WIDTH  = 7,
    parameter int unsigned BCD_DIGITS = 2,
    parameter int unsigned HOUR_IDX   = 2,
    parameter logic [NUM_FIELDS-1:0] LZ_MASK = 3'b100
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_start,
    input  logic [NUM_FIELDS*BIN_WIDTH-1:0]  i_fields,
    input  logic                             i_mode_12h,
    input  logic                             i_blank_lz,
    output logic                             o_busy,
    output logic                             o_valid,
    output logic [NUM_FIELDS*BCD_DIGITS*4-1:0] o_bcd,
    output logic [NUM_FIELDS-1:0]            o_overflow,
    output logic                             o_pm
);

    localparam int unsigned BcdW   = BCD_DIGITS * 4;
    localparam int unsigned OutW   = NUM_FIELDS * BcdW;
    localparam int unsigned FieldW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int unsigned BitW   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
    localparam int unsigned MaxVal = 10 ** BCD_DIGITS;
    localparam logic [FieldW-1:0] LastField = FieldW'(NUM_FIELDS - 1);
    localparam logic [BitW-1:0]   LastBit   = BitW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                 state_q, state_d;
    logic [FieldW-1:0]      field_q, field_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [BcdW-1:0]        bcd_q, bcd_d;
    logic [BIN_WIDTH-1:0]   snap_q [NUM_FIELDS];
    logic [BIN_WIDTH-1:0]   snap_d [NUM_FIELDS];
    logic [NUM_FIELDS-1:0]  ovf_q, ovf_d;
    logic                   pm_q, pm_d;
    logic                   blank_q, blank_d;
    logic [OutW-1:0]        stage_q, stage_d;
    logic [OutW-1:0]        out_bcd_q, out_bcd_d;
    logic [NUM_FIELDS-1:0]  out_ovf_q, out_ovf_d;
    logic                   out_pm_q, out_pm_d;
    logic                   valid_q, valid_d;

    // Snapshot preprocessing: remap, then overflow detection on the remapped value.
    logic [BIN_WIDTH-1:0]   snap_in [NUM_FIELDS];
    logic [NUM_FIELDS-1:0]  ovf_in;
    logic                   pm_in;
    logic [BIN_WIDTH-1:0]   hour_raw;

    always_comb begin
        hour_raw = i_fields[HOUR_IDX*BIN_WIDTH +: BIN_WIDTH];
        pm_in    = i_mode_12h && (32'(hour_raw) >= 32'd12);
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
            snap_in[f] = i_fields[f*BIN_WIDTH +: BIN_WIDTH];
            if (f == HOUR_IDX && i_mode_12h) begin
                if (32'(snap_in[f]) == 32'd0) begin
                    snap_in[f] = BIN_WIDTH'(12);
                end else if (32'(snap_in[f]) >= 32'd13 && 32'(snap_in[f]) <= 32'd23) begin
                    snap_in[f] = snap_in[f] - BIN_WIDTH'(12);
                end
            end
            ovf_in[f] = 32'(snap_in[f]) >= MaxVal;
        end
    end

    // One double-dabble step on the current field, plus the finished-field post-processing.
    logic [BcdW-1:0] adj;
    logic [BcdW-1:0] shifted;
    logic [BcdW-1:0] fin;
    logic            cur_bit;
    logic            lead;

    always_comb begin
        adj = bcd_q;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (bcd_q[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
            end
        end
        cur_bit = snap_q[field_q][LastBit - bit_q];
        shifted = {adj[BcdW-2:0], cur_bit};

        fin  = shifted;
        lead = 1'b1;
        if (ovf_q[field_q]) begin
            for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
                fin[d*4 +: 4] = 4'd9;
            end
        end else if (blank_q && LZ_MASK[field_q]) begin
            // Walk from the MSD down; digit 0 always stays visible.
            for (int d = int'(BCD_DIGITS) - 1; d >= 1; d--) begin
                if (lead && fin[d*4 +: 4] == 4'd0) begin
                    fin[d*4 +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= StIdle;
            field_q   <= '0;
            bit_q     <= '0;
            bcd_q     <= '0;
            snap_q    <= '{default: '0};
            ovf_q     <= '0;
            pm_q      <= 1'b0;
            blank_q   <= 1'b0;
            stage_q   <= '0;
            out_bcd_q <= '0;
            out_ovf_q <= '0;
            out_pm_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            field_q   <= field_d;
            bit_q     <= bit_d;
            bcd_q     <= bcd_d;
            snap_q    <= snap_d;
            ovf_q     <= ovf_d;
            pm_q      <= pm_d;
            blank_q   <= blank_d;
            stage_q   <= stage_d;
            out_bcd_q <= out_bcd_d;
            out_ovf_q <= out_ovf_d;
            out_pm_q  <= out_pm_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StShift;
            StShift: if (bit_q == LastBit && field_q == LastField) state_d = StDone;
            StDone:  state_d = i_start ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values.
    always_comb begin
        field_d   = field_q;
        bit_d     = bit_q;
        bcd_d     = bcd_q;
        snap_d    = snap_q;
        ovf_d     = ovf_q;
        pm_d      = pm_q;
        blank_d   = blank_q;
        stage_d   = stage_q;
        out_bcd_d = out_bcd_q;
        out_ovf_d = out_ovf_q;
        out_pm_d  = out_pm_q;
        valid_d   = 1'b0;

        if (state_q == StDone) begin
            out_bcd_d = stage_q;
            out_ovf_d = ovf_q;
            out_pm_d  = pm_q;
            valid_d   = 1'b1;
        end

        if (state_q == StShift) begin
            if (bit_q == LastBit) begin
                stage_d[32'(field_q)*BcdW +: BcdW] = fin;
                bcd_d   = '0;
                bit_d   = '0;
                field_d = field_q + 1'b1;
            end else begin
                bcd_d = shifted;
                bit_d = bit_q + 1'b1;
            end
        end else if (i_start) begin
            // Idle or done: a start takes a fresh snapshot.
            snap_d  = snap_in;
            ovf_d   = ovf_in;
            pm_d    = pm_in;
            blank_d = i_blank_lz;
            field_d = '0;
            bit_d   = '0;
            bcd_d   = '0;
        end
    end

    // Outputs.
    always_comb begin
        o_busy     = (state_q != StIdle);
        o_valid    = valid_q;
        o_bcd      = out_bcd_q;
        o_overflow = out_ovf_q;
        o_pm       = out_pm_q;
    end

endmodule

// File: tb/tb_clock_bcd_seq.sv
module tb_clock_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [20:0] fields = '0;
    logic        mode_12h = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic        valid;
    logic [23:0] bcd;
    logic [2:0]  ovf;
    logic        pm;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clock_bcd_seq dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .i_fields   (fields),
        .i_mode_12h (mode_12h),
        .i_blank_lz (blank_lz),
        .o_busy     (busy),
        .o_valid    (valid),
        .o_bcd      (bcd),
        .o_overflow (ovf),
        .o_pm       (pm)
    );

    function automatic logic [20:0] pack(input int h, input int m, input int s);
        return {7'(h), 7'(m), 7'(s)};
    endfunction

    // Pulse start for one edge; returns #1 after that edge (edge k).
    task automatic start_conv(input int h, input int m, input int s, input logic m12,
                              input logic blk);
        @(negedge clk);
        fields   = pack(h, m, s);
        mode_12h = m12;
        blank_lz = blk;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycles until o_valid is seen (sampled #1 after each edge); -1 on timeout.
    task automatic wait_valid(output int n);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bcd !== 24'h0) begin n_err++; $display("FAIL reset_bcd got %h want 0", bcd); end
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (ovf !== 3'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_vec++; if (pm !== 1'b0) begin n_err++; $display("FAIL reset_pm got %b want 0", pm); end
        rst_n = 1'b1;
    endtask

    task automatic test_24h();
        int n;
        start_conv(23, 7, 59, 1'b0, 1'b0);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_k1 got %b want 1", busy); end
        wait_valid(n);
        n_vec++; if (n !== 22) begin n_err++; $display("FAIL latency got %0d want 22", n); end
        n_vec++; if (bcd !== 24'h230759) begin n_err++; $display("FAIL bcd_24h got %h want 230759", bcd); end
        n_vec++; if (pm !== 1'b0) begin n_err++; $display("FAIL pm_24h got %b want 0", pm); end
        n_vec++; if (ovf !== 3'b0) begin n_err++; $display("FAIL ovf_24h got %b want 0", ovf); end
        @(posedge clk);
        #1;
        n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL valid_pulse got %b want 0", valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after got %b want 0", busy); end
        n_vec++; if (bcd !== 24'h230759) begin n_err++; $display("FAIL bcd_hold got %h want 230759", bcd); end
    endtask

    task automatic test_12h();
        int          hs [5] = '{0, 13, 12, 23, 0};
        int          ms [5] = '{0, 5, 0, 0, 0};
        logic        m12 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        blk [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [23:0] eb [5] = '{24'h120000, 24'hF10500, 24'h120000, 24'h110000, 24'hF00000};
        logic        ep [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int n;
        for (int i = 0; i < 5; i++) begin
            start_conv(hs[i], ms[i], 0, m12[i], blk[i]);
            wait_valid(n);
            n_vec++;
            if (n !== 22 || bcd !== eb[i]) begin
                n_err++;
                $display("FAIL 12h_bcd[%0d] got %h (lat %0d) want %h (lat 22)", i, bcd, n, eb[i]);
            end
            n_vec++; if (pm !== ep[i]) begin n_err++; $display("FAIL 12h_pm[%0d] got %b want %b", i, pm, ep[i]); end
        end
    endtask

    task automatic test_overflow();
        int n;
        start_conv(0, 0, 127, 1'b0, 1'b0);
        wait_valid(n);
        n_vec++; if (bcd !== 24'h000099) begin n_err++; $display("FAIL ovf127_bcd got %h want 000099", bcd); end
        n_vec++; if (ovf !== 3'b001) begin n_err++; $display("FAIL ovf127_flag got %b want 001", ovf); end
        start_conv(0, 0, 99, 1'b0, 1'b0);
        wait_valid(n);
        n_vec++; if (bcd !== 24'h000099) begin n_err++; $display("FAIL ovf99_bcd got %h want 000099", bcd); end
        n_vec++; if (ovf !== 3'b000) begin n_err++; $display("FAIL ovf99_flag got %b want 000", ovf); end
        start_conv(100, 0, 0, 1'b0, 1'b0);
        wait_valid(n);
        n_vec++; if (bcd !== 24'h990000) begin n_err++; $display("FAIL ovfh_bcd got %h want 990000", bcd); end
        n_vec++; if (ovf !== 3'b100) begin n_err++; $display("FAIL ovfh_flag got %b want 100", ovf); end
    endtask

    task automatic test_busy_ignore();
        int          cnt = 0;
        int          at = -1;
        logic [23:0] got = '0;
        start_conv(3, 2, 1, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        fields = '1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 6; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                cnt++;
                at  = c;
                got = bcd;
            end
        end
        n_vec++; if (cnt !== 1) begin n_err++; $display("FAIL busy_valid_count got %0d want 1", cnt); end
        n_vec++; if (at !== 22) begin n_err++; $display("FAIL busy_latency got %0d want 22", at); end
        n_vec++; if (got !== 24'h030201) begin n_err++; $display("FAIL busy_bcd got %h want 030201", got); end
    endtask

    task automatic test_reset_abort();
        int cnt = 0;
        fields = '0;
        start_conv(4, 5, 6, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_vec++; if (bcd !== 24'h0) begin n_err++; $display("FAIL abort_bcd got %h want 0", bcd); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (valid) cnt++;
        end
        n_vec++; if (cnt !== 0) begin n_err++; $display("FAIL abort_valid_count got %0d want 0", cnt); end
        n_vec++; if (bcd !== 24'h0) begin n_err++; $display("FAIL abort_bcd_hold got %h want 0", bcd); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] eb [3] = '{24'h212010, 24'h005945, 24'h090100};
        int n;
        @(negedge clk);
        fields   = pack(21, 20, 10);
        mode_12h = 1'b0;
        blank_lz = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1 fields = pack(0, 59, 45);
        for (int i = 0; i < 3; i++) begin
            wait_valid(n);
            n_vec++; if (n !== 22) begin n_err++; $display("FAIL b2b_period[%0d] got %0d want 22", i, n); end
            n_vec++; if (bcd !== eb[i]) begin n_err++; $display("FAIL b2b_bcd[%0d] got %h want %h", i, bcd, eb[i]); end
            if (i == 0) fields = pack(9, 1, 0);
            if (i == 1) start = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_24h();
        test_12h();
        test_overflow();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
